mem_arbiter: RTL and testbench

- N-master arbiter in front of the single-port-pair `ram`. Successor to the fixed two-way booted-select muxing between `bios` and `core`.
- Any number of masters (BIOS, core fetch, core LSU, DMA) share the RAM read and write ports.
- Fair round-robin arbitration, a per-master acknowledge, and read-data return routed back to the requester after a fixed RAM latency.

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM read/write port pair among NUM_MASTERS masters,
// with per-master ack and read-return routing. Define ARB_LOCK_EN to add exclusive-owner locking.
module mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int READ_LAT    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clk_en,
`ifdef ARB_LOCK_EN
  input  logic                            i_lock,
  input  logic [$clog2(NUM_MASTERS)-1:0]  i_lock_sel,
`endif
  input  logic [NUM_MASTERS-1:0]          i_read_req,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   i_read_addr,
  input  logic [NUM_MASTERS-1:0]          i_write_enable,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] i_byte_enable,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   i_write_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   i_write_data,
  output logic [NUM_MASTERS-1:0]          o_ack,
  output logic [NUM_MASTERS-1:0]          o_rvalid,
  output logic [DATA_W-1:0]               o_read_data,
  output logic                            o_read_req,
  output logic [ADDR_W-1:0]               o_read_addr,
  input  logic [DATA_W-1:0]               i_read_data,
  output logic                            o_write_enable,
  output logic [DATA_W/8-1:0]             o_byte_enable,
  output logic [ADDR_W-1:0]               o_write_addr,
  output logic [DATA_W-1:0]               o_write_data
);

  localparam int ID_W = $clog2(NUM_MASTERS);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] eligible;
  logic                   grant_en;
  logic                   grant_valid;
  logic [ID_W-1:0]        grant_idx;
  logic [ID_W-1:0]        sel_idx;
  logic [ID_W-1:0]        rr_ptr_reg;
  logic [ID_W-1:0]        rr_ptr_next;
  logic                   pipe_valid_reg [READ_LAT];
  logic [ID_W-1:0]        pipe_id_reg    [READ_LAT];

  // Reset and a stalled clock both suppress any grant.
  assign grant_en = rst & clk_en;

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_req
      assign req[gi] = i_read_req[gi] | i_write_enable[gi];
`ifdef ARB_LOCK_EN
      assign eligible[gi] = req[gi] & (~i_lock | (i_lock_sel == ID_W'(gi)));
`else
      assign eligible[gi] = req[gi];
`endif
    end
  endgenerate

  // Scan from the farthest candidate back to rr_ptr so the nearest eligible master wins.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (grant_en && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_valid) begin
      rr_ptr_next = (grant_idx == ID_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;
    end
`ifdef ARB_LOCK_EN
    if (i_lock) rr_ptr_next = rr_ptr_reg;
`endif
  end

  always_comb begin
    o_ack = '0;
    if (grant_valid) o_ack[grant_idx] = 1'b1;
  end

  // With no grant the RAM fields simply follow master 0.
  assign sel_idx        = grant_valid ? grant_idx : '0;
  assign o_read_req     = grant_valid & i_read_req[grant_idx];
  assign o_write_enable = grant_valid & i_write_enable[grant_idx];
  assign o_read_addr    = i_read_addr[sel_idx*ADDR_W +: ADDR_W];
  assign o_write_addr   = i_write_addr[sel_idx*ADDR_W +: ADDR_W];
  assign o_write_data   = i_write_data[sel_idx*DATA_W +: DATA_W];
  assign o_byte_enable  = i_byte_enable[sel_idx*BE_W +: BE_W];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_reg <= '0;
      for (int s = 0; s < READ_LAT; s++) pipe_valid_reg[s] <= 1'b0;
    end else if (clk_en) begin
      rr_ptr_reg        <= rr_ptr_next;
      pipe_valid_reg[0] <= o_read_req;
      pipe_id_reg[0]    <= grant_idx;
      for (int s = 1; s < READ_LAT; s++) begin
        pipe_valid_reg[s] <= pipe_valid_reg[s-1];
        pipe_id_reg[s]    <= pipe_id_reg[s-1];
      end
    end
  end

  // Return tag tracks the RAM pipeline, which freezes on the same clk_en.
  always_comb begin
    o_rvalid = '0;
    if (pipe_valid_reg[READ_LAT-1]) o_rvalid[pipe_id_reg[READ_LAT-1]] = 1'b1;
  end

  assign o_read_data = i_read_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level arbitration/RAM model checks every cycle,
// plus directed round-robin, byte-write, clk_en stall, reset-discard and lock sequences.
module tb_mem_arbiter;
  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int BW  = DW / 8;
  localparam int IW  = $clog2(N);
  localparam int NCYC_RAND = 2500;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_en = 1'b1;
  logic [N-1:0]    i_read_req, i_write_enable;
  logic [N*AW-1:0] i_read_addr, i_write_addr;
  logic [N*BW-1:0] i_byte_enable;
  logic [N*DW-1:0] i_write_data;
  logic [N-1:0]    o_ack, o_rvalid;
  logic [DW-1:0]   o_read_data, i_read_data, o_write_data;
  logic            o_read_req, o_write_enable;
  logic [AW-1:0]   o_read_addr, o_write_addr;
  logic [BW-1:0]   o_byte_enable;
`ifdef ARB_LOCK_EN
  logic            i_lock = 1'b0;
  logic [IW-1:0]   i_lock_sel = '0;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
`ifdef ARB_LOCK_EN
    .i_lock(i_lock), .i_lock_sel(i_lock_sel),
`endif
    .i_read_req(i_read_req), .i_read_addr(i_read_addr),
    .i_write_enable(i_write_enable), .i_byte_enable(i_byte_enable),
    .i_write_addr(i_write_addr), .i_write_data(i_write_data),
    .o_ack(o_ack), .o_rvalid(o_rvalid), .o_read_data(o_read_data),
    .o_read_req(o_read_req), .o_read_addr(o_read_addr), .i_read_data(i_read_data),
    .o_write_enable(o_write_enable), .o_byte_enable(o_byte_enable),
    .o_write_addr(o_write_addr), .o_write_data(o_write_data)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [BW-1:0] be);
    merge = old;
    for (int b = 0; b < BW; b++) if (be[b]) merge[b*8 +: 8] = d[b*8 +: 8];
  endfunction

  // RAM behind the arbiter: LAT-cycle read pipeline, frozen with clk_en.
  logic [DW-1:0] ram [64];
  logic [DW-1:0] ram_pipe [LAT];
  always @(posedge clk) begin
    if (clk_en) begin
      ram_pipe[0] <= ram[o_read_addr[7:2]];
      for (int s = 1; s < LAT; s++) ram_pipe[s] <= ram_pipe[s-1];
      if (o_write_enable)
        ram[o_write_addr[7:2]] <= merge(ram[o_write_addr[7:2]], o_write_data, o_byte_enable);
    end
  end
  assign i_read_data = ram_pipe[LAT-1];

  // Master-side pending transactions.
  logic          pend    [N];
  logic          p_rd    [N];
  logic          p_wr    [N];
  logic [AW-1:0] p_raddr [N];
  logic [AW-1:0] p_waddr [N];
  logic [DW-1:0] p_wdata [N];
  logic [BW-1:0] p_be    [N];

  // Reference model state.
  logic [DW-1:0] ref_mem [64];
  int            rr = 0;
  int            cnt = 0;
  int            ret_id [int];
  logic [DW-1:0] ret_data [int];
  logic [N-1:0]  obs_log [$];
  logic [N-1:0]  rv_seen;
  logic          m0_got;
  logic [DW-1:0] m0_data;
  logic [N-1:0]  gen_mask;
  bit            rand_mode = 1'b0;
  int            gen_rate = 0;
  int            gen_kind = 0;
  int            total = 0;
  int            bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit allowed(input int m);
`ifdef ARB_LOCK_EN
    return !i_lock || (m == int'(i_lock_sel));
`else
    return m >= 0;
`endif
  endfunction

  function automatic int exp_grant();
    if (!rst || !clk_en) return -1;
    for (int k = 0; k < N; k++) begin
      int m;
      m = (rr + k) % N;
      if (pend[m] && allowed(m)) return m;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int m = 0; m < N; m++) begin
      i_read_req[m]               = pend[m] & p_rd[m];
      i_write_enable[m]           = pend[m] & p_wr[m];
      i_read_addr[m*AW +: AW]     = p_raddr[m];
      i_write_addr[m*AW +: AW]    = p_waddr[m];
      i_write_data[m*DW +: DW]    = p_wdata[m];
      i_byte_enable[m*BW +: BW]   = p_be[m];
    end
  endtask

  task automatic set_req(input int m, input logic rd, input logic wr, input logic [AW-1:0] ra,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [BW-1:0] be);
    pend[m] = 1'b1; p_rd[m] = rd; p_wr[m] = wr;
    p_raddr[m] = ra; p_waddr[m] = wa; p_wdata[m] = wd; p_be[m] = be;
  endtask

  task automatic new_req(input int m, input int kind);
    int k;
    k = (kind == 2) ? int'($urandom_range(2)) : kind;
    set_req(m, k != 1, k != 0, $urandom, $urandom, $urandom, BW'($urandom));
  endtask

  task automatic gen();
    for (int m = 0; m < N; m++)
      if (!pend[m] && gen_mask[m] && (int'($urandom_range(99)) < gen_rate)) new_req(m, gen_kind);
  endtask

  task automatic randomize_ctrl();
    rst    = ($urandom_range(99) >= 2);
    clk_en = !rst || ($urandom_range(99) < 80);
`ifdef ARB_LOCK_EN
    if ($urandom_range(99) < 4)  i_lock = ~i_lock;
    if ($urandom_range(99) < 10) i_lock_sel = IW'($urandom_range(N-1));
`endif
  endtask

  // One clock: check outputs at negedge, advance the model at posedge, then new stimulus.
  task automatic cycle();
    int g, sel;
    logic [N-1:0] ev, ea;
    drive();
    @(negedge clk);
    g   = exp_grant();
    sel = (g >= 0) ? g : 0;
    ea  = '0;
    if (g >= 0) ea[g] = 1'b1;
    obs_log.push_back(o_ack);
    check("ack", o_ack, ea);
    check("ram_rd", o_read_req, (g >= 0) && p_rd[sel]);
    check("ram_wr", o_write_enable, (g >= 0) && p_wr[sel]);
    check("ram_raddr", o_read_addr, p_raddr[sel]);
    check("ram_waddr", o_write_addr, p_waddr[sel]);
    check("ram_wdata", o_write_data, p_wdata[sel]);
    check("ram_be", o_byte_enable, p_be[sel]);
    if (rst) begin
      ev = '0;
      if (ret_id.exists(cnt)) ev[ret_id[cnt]] = 1'b1;
      check("rvalid", o_rvalid, ev);
      if (ev != '0) check("rdata", o_read_data, ret_data[cnt]);
      rv_seen = rv_seen | o_rvalid;
      if (o_rvalid[0]) begin
        m0_got  = 1'b1;
        m0_data = o_read_data;
      end
    end
    @(posedge clk);
    if (!rst) begin
      rr = 0;
      ret_id.delete();
      ret_data.delete();
    end else if (clk_en) begin
      if (g >= 0) begin
        if (p_rd[g]) begin
          ret_id[cnt+LAT]   = g;
          ret_data[cnt+LAT] = ref_mem[p_raddr[g][7:2]];
        end
        if (p_wr[g]) ref_mem[p_waddr[g][7:2]] = merge(ref_mem[p_waddr[g][7:2]], p_wdata[g], p_be[g]);
`ifdef ARB_LOCK_EN
        if (!i_lock) rr = (g + 1) % N;
`else
        rr = (g + 1) % N;
`endif
        pend[g] = 1'b0;
      end
      cnt++;
    end
    #1;
    if (rand_mode) randomize_ctrl();
    gen();
  endtask

  task automatic drain();
    gen_rate = 0;
`ifdef ARB_LOCK_EN
    i_lock = 1'b0;
`endif
    repeat (N + LAT + 3) cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [N-1:0] exp_seq [5];
    for (int m = 0; m < N; m++) set_req(m, 1'b0, 1'b0, '0, '0, '0, '0);
    for (int m = 0; m < N; m++) pend[m] = 1'b0;
    for (int i = 0; i < 64; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    gen_mask = '1;
    rv_seen  = '0;
    m0_got   = 1'b0;
    m0_data  = '0;

    // Reset, then every master holding a read: grants rotate 0,1,2,3 and wrap to 0.
    rst = 1'b0; clk_en = 1'b1;
    repeat (3) cycle();
    rst = 1'b1;
    gen_rate = 100; gen_kind = 0; gen();
    base = obs_log.size();
    repeat (5) cycle();
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) check("rr_order", obs_log[base+i], exp_seq[i]);

    // m1 byte-enabled write, then m0 reads it back.
    drain();
    set_req(1, 1'b0, 1'b1, 32'h0, 32'h40, 32'hDEADBEEF, 4'b0011);
    base = obs_log.size();
    cycle();
    check("wr_ack", obs_log[base], 4'b0010);
    set_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 4'h0);
    m0_got = 1'b0;
    for (int i = 0; i < 10 && !m0_got; i++) cycle();
    check("readback_seen", m0_got, 1'b1);
    check("readback_data", m0_data, 32'h0000BEEF);

    // m0 read, two stalled cycles, then m2 read.
    drain();
    set_req(0, 1'b1, 1'b0, 32'h104, 32'h0, 32'h0, 4'h0);
    cycle();
    clk_en = 1'b0;
    cycle(); cycle();
    clk_en = 1'b1;
    set_req(2, 1'b1, 1'b0, 32'h208, 32'h0, 32'h0, 4'h0);
    cycle();
    repeat (LAT + 3) cycle();

    // Reset while a read is in flight: no return, pointer back to 0.
    drain();
    set_req(0, 1'b1, 1'b0, 32'h0C, 32'h0, 32'h0, 4'h0);
    cycle();
    rst = 1'b0;
    cycle(); cycle();
    rst = 1'b1;
    rv_seen = '0;
    repeat (LAT + 2) cycle();
    check("rst_discard", rv_seen, '0);
    gen_rate = 100; gen_kind = 0; gen();
    base = obs_log.size();
    cycle();
    check("post_rst_m0", obs_log[base], 4'b0001);

`ifdef ARB_LOCK_EN
    // Lock onto m0 while m0 and m1 both request; m1 follows once unlocked.
    drain();
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 4'h0);
    cycle();
    i_lock = 1'b1; i_lock_sel = '0;
    gen_mask = 4'b0011; gen_rate = 100; gen_kind = 0; gen();
    base = obs_log.size();
    repeat (10) cycle();
    for (int i = 0; i < 10; i++) check("lock_m0", obs_log[base+i], 4'b0001);
    i_lock = 1'b0;
    base = obs_log.size();
    cycle();
    check("unlock_m1", obs_log[base], 4'b0010);
    gen_mask = '1;
`endif

    // Random traffic with stalls, sporadic resets and mixed read/write transactions.
    drain();
    gen_mask = '1; gen_rate = 40; gen_kind = 2; rand_mode = 1'b1;
    repeat (NCYC_RAND) cycle();
    rand_mode = 1'b0; rst = 1'b1; clk_en = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
